// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares one main-memory port between the data-side miss path and instruction fetch.
// Optional ARB_RR_EN selects two-entry round-robin; otherwise fixed priority D over I.
module main_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_gnt_i, r_we, r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic          w_any, w_gnt_i, w_ack, w_to, w_start;
    assign w_any   = d_req | i_req;
    assign w_start = (r_state == IDLE) & w_any;
    assign w_ack   = (r_state == BUSY) & mem_ack;
    assign w_to    = (TIMEOUT != 0) && (r_state == BUSY) && (r_cnt == CW'(TIMEOUT - 1));
`ifdef ARB_RR_EN
    // r_pri_i marks the port not granted last; it wins a tie
    logic r_pri_i;
    assign w_gnt_i = i_req & (~d_req | r_pri_i);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pri_i <= 1'b0;
        else if (w_start) r_pri_i <= ~w_gnt_i;
    end
`else
    assign w_gnt_i = i_req & ~d_req;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (w_any ? BUSY : IDLE) :
                 r_state == BUSY ? ((w_ack | w_to) ? DONE : BUSY) : IDLE;
    end
    always_comb begin
        mem_req   = r_state == BUSY;
        d_done    = (r_state == DONE) & ~r_gnt_i;
        i_done    = (r_state == DONE) & r_gnt_i;
        d_stall   = d_req & ~d_done;
        i_stall   = i_req & ~i_done;
        d_rdata   = r_rdata;
        i_rdata   = r_rdata;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        err       = r_err;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_i <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_gnt_i <= w_gnt_i;
                r_we    <= ~w_gnt_i & d_we;
                r_addr  <= w_gnt_i ? i_addr : d_addr;
                r_wdata <= (~w_gnt_i & d_we) ? d_wdata : '0;
            end
            r_cnt <= r_state == BUSY ? r_cnt + CW'(1) : '0;
            if (w_ack) r_rdata <= mem_rdata;
            else if (w_to) r_rdata <= '0;
            if (w_to & ~w_ack) r_err <= 1'b1;
        end
    end
endmodule
